pipelined_datapath: RTL and testbench



---
 rtl/pipelined_datapath_pkg.sv | 33 +++
 rtl/pipelined_datapath_if.sv | 11 +
 rtl/pipelined_alu.sv | 29 ++
 rtl/pipelined_datapath.sv | 76 +++++++
 tb/tb_pipelined_datapath.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipelined_datapath_pkg.sv
// Shared encodings for the 3-stage ALU datapath: instruction field positions,
// ALU function codes and the immediate sign-extension helper.
`timescale 1ns/1ps
package pipelined_datapath_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned FUNC_W  = 3;

  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned IMM_BIT = 3;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_MOV  = 3'b000,
    FUNC_NOT  = 3'b001,
    FUNC_AND  = 3'b010,
    FUNC_ADD  = 3'b011,
    FUNC_NOR  = 3'b100,
    FUNC_NAND = 3'b101,
    FUNC_SUB  = 3'b110,
    FUNC_SLT  = 3'b111
  } alu_func_e;

  function automatic logic [WORD_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
    return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/pipelined_datapath_if.sv
// Instruction-in / result-out bus of the pipelined datapath.
`timescale 1ns/1ps
interface pipelined_datapath_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] InstrIn;
  logic [DATA_W-1:0] Out;

  modport master (output InstrIn, input Out);
  modport slave  (input InstrIn, output Out);
endinterface

// File: rtl/pipelined_alu.sv
// Purely combinational ALU: eight functions selected by a 3-bit code.
`timescale 1ns/1ps
module pipelined_alu
  import pipelined_datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_func_e         func,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (func)
      FUNC_MOV:  y = a;
      FUNC_NOT:  y = ~a;
      FUNC_AND:  y = a & b;
      FUNC_ADD:  y = a + b;
      FUNC_NOR:  y = ~(a | b);
      FUNC_NAND: y = ~(a & b);
      FUNC_SUB:  y = a - b;
      FUNC_SLT:  y = DATA_W'($signed(a) < $signed(b));
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath.sv
// 3-stage ALU pipeline (IR -> decode/read -> execute/write-back) with a 32x32
// register file; no forwarding, so dependents must be spaced by software.
`timescale 1ns/1ps
module pipelined_datapath
  import pipelined_datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_datapath_if.slave  bus
);

  // op[5:4] are don't-care, so only the low 30 instruction bits are latched.
  logic [OP_LSB+IMM_BIT:0] ir;

  logic [DATA_W-1:0] regs [NREG];

  logic [REG_AW-1:0] rs, rt, rd, dest_d;
  logic [IMM_W-1:0]  imm;
  logic              imm_sel;
  alu_func_e         func_d;
  logic [DATA_W-1:0] rs_val, rt_val, opnd_b;

  logic [DATA_W-1:0] a_q, b_q, alu_y, out_q;
  alu_func_e         func_q;
  logic [REG_AW-1:0] dest_q;

  always_comb begin
    rs      = ir[RS_LSB +: REG_AW];
    rt      = ir[RT_LSB +: REG_AW];
    rd      = ir[RD_LSB +: REG_AW];
    imm     = ir[IMM_LSB +: IMM_W];
    imm_sel = ir[OP_LSB + IMM_BIT];
    func_d  = alu_func_e'(ir[OP_LSB +: FUNC_W]);
    rs_val  = (rs == '0) ? '0 : regs[rs];
    rt_val  = (rt == '0) ? '0 : regs[rt];
    opnd_b  = imm_sel ? sign_ext(imm) : rt_val;
    dest_d  = imm_sel ? rt : rd;
  end

  pipelined_alu #(.DATA_W(DATA_W)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .func (func_q),
    .y    (alu_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      func_q <= FUNC_MOV;
      dest_q <= '0;
      out_q  <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else begin
      ir     <= bus.InstrIn[OP_LSB+IMM_BIT:0];
      a_q    <= rs_val;
      b_q    <= opnd_b;
      func_q <= func_d;
      dest_q <= dest_d;
      out_q  <= alu_y;
      if (dest_q != '0) begin
        regs[dest_q] <= alu_y;
      end
    end
  end

  assign bus.Out = out_q;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Bench for pipelined_datapath: directed vectors plus random instruction
// streams against a register-level model with a two-instruction commit lag.
`timescale 1ns/1ps
module tb_pipelined_datapath;
  import pipelined_datapath_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pipelined_datapath_if #(.DATA_W(32)) bus ();

  pipelined_datapath #(.DATA_W(32), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    bit          has_c;
    logic [31:0] c;
    int          id;
  } exp_t;

  logic [31:0] m_regs [32];
  exp_t        pipe_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural meaning of one instruction against the current model state.
  function automatic void model_exec(input logic [31:0] instr,
                                     output logic [31:0] res, output logic [4:0] dest);
    logic [31:0] a, b;
    logic [2:0]  f;
    f = instr[28:26];
    a = m_regs[instr[25:21]];
    if (instr[29]) begin
      b    = {{16{instr[15]}}, instr[15:0]};
      dest = instr[20:16];
    end else begin
      b    = m_regs[instr[20:16]];
      dest = instr[15:11];
    end
    case (f)
      3'd0: res = a;
      3'd1: res = ~a;
      3'd2: res = a & b;
      3'd3: res = a + b;
      3'd4: res = ~(a | b);
      3'd5: res = ~(a & b);
      3'd6: res = a - b;
      default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{res: '0, dest: '0, has_c: 1'b0, c: '0, id: 0};
    for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
    pipe_q.delete();
    repeat (3) pipe_q.push_back(z);
  endtask

  // Instruction issued now sees writes of everything issued >=2 slots earlier.
  task automatic issue(input logic [31:0] instr, input bit has_c = 1'b0,
                       input logic [31:0] c = '0, input int id = 0);
    exp_t e, n;
    @(negedge clk);
    e = pipe_q.pop_front();
    check("out", bus.Out, e.res);
    if (e.has_c) check($sformatf("vec%0d", e.id), bus.Out, e.c);
    if (pipe_q[0].dest != 5'd0) m_regs[pipe_q[0].dest] = pipe_q[0].res;
    model_exec(instr, n.res, n.dest);
    n.has_c = has_c;
    n.c     = c;
    n.id    = id;
    pipe_q.push_back(n);
    bus.InstrIn = instr;
  endtask

  task automatic drain();
    repeat (3) issue(32'h0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.InstrIn = '0;
    #1 check("rst_out", bus.Out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    bus.InstrIn = '0;
    #1 check("mid_rst_out", bus.Out, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] r_op(input alu_func_e f, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {3'b000, f, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] i_op(input alu_func_e f, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {3'b001, f, rs, rt, imm};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.InstrIn = '0;
    model_reset();

    apply_reset();
    issue(r_op(FUNC_MOV, 5'd7, 5'd0, 5'd7), 1'b1, 32'd7,  1);
    issue(r_op(FUNC_ADD, 5'd2, 5'd1, 5'd2), 1'b1, 32'd3,  2);
    issue(r_op(FUNC_ADD, 5'd4, 5'd3, 5'd4), 1'b1, 32'd7,  3);
    issue(r_op(FUNC_ADD, 5'd6, 5'd5, 5'd6), 1'b1, 32'd11, 4);
    drain();

    apply_reset();
    issue(r_op(FUNC_ADD, 5'd2, 5'd1, 5'd2), 1'b1, 32'd3, 5);
    issue(r_op(FUNC_ADD, 5'd2, 5'd0, 5'd8), 1'b1, 32'd2, 6);
    drain();

    apply_reset();
    issue(r_op(FUNC_ADD, 5'd2, 5'd1, 5'd2), 1'b1, 32'd3, 7);
    issue(32'h0);
    issue(r_op(FUNC_ADD, 5'd2, 5'd0, 5'd8), 1'b1, 32'd3, 8);
    drain();

    apply_reset();
    issue(i_op(FUNC_ADD, 5'd2, 5'd1,  16'd2),    1'b1, 32'd4,         9);
    issue(i_op(FUNC_SUB, 5'd2, 5'd1,  16'd5),    1'b1, 32'hFFFF_FFFD, 10);
    issue(i_op(FUNC_ADD, 5'd5, 5'd20, 16'hFFFF), 1'b1, 32'd4,         11);
    issue(r_op(FUNC_NOT,  5'd2, 5'd3, 5'd10),    1'b1, 32'hFFFF_FFFD, 12);
    issue(r_op(FUNC_AND,  5'd2, 5'd3, 5'd10),    1'b1, 32'd2,         13);
    issue(r_op(FUNC_NOR,  5'd2, 5'd3, 5'd10),    1'b1, 32'hFFFF_FFFC, 14);
    issue(r_op(FUNC_NAND, 5'd2, 5'd3, 5'd10),    1'b1, 32'hFFFF_FFFD, 15);
    issue(r_op(FUNC_SUB,  5'd2, 5'd3, 5'd11),    1'b1, 32'hFFFF_FFFF, 16);
    drain();

    apply_reset();
    issue(r_op(FUNC_SLT, 5'd2, 5'd3, 5'd12), 1'b1, 32'd1,         17);
    issue(r_op(FUNC_SLT, 5'd2, 5'd1, 5'd13), 1'b1, 32'd0,         18);
    issue(r_op(FUNC_SUB, 5'd2, 5'd3, 5'd9),  1'b1, 32'hFFFF_FFFF, 19);
    issue(32'h0);
    issue(r_op(FUNC_SLT, 5'd9, 5'd1, 5'd14), 1'b1, 32'd1,         20);
    issue(r_op(FUNC_ADD, 5'd2, 5'd1, 5'd0),  1'b1, 32'd3,         21);
    issue(32'h0);
    issue(r_op(FUNC_MOV, 5'd0, 5'd0, 5'd5),  1'b1, 32'd0,         22);
    drain();

    for (int i = 0; i < 300; i++) begin
      logic [31:0] instr;
      instr = $urandom();
      if ($urandom_range(0, 7) == 0) instr = 32'h0;
      issue(instr);
    end
    mid_reset();

    for (int i = 0; i < 32; i++) begin
      issue(r_op(FUNC_MOV, 5'(i), 5'd0, 5'(i)), 1'b1, 32'(i), 100 + i);
    end
    drain();

    for (int i = 0; i < 200; i++) begin
      issue($urandom());
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
